syndrome_scheduler: RTL
=======================

Name: syndrome_scheduler

Overview:
- Sequences one shared Horner polynomial evaluator over NSYM consecutive roots alpha^(FCR+j) to produce the Reed-Solomon syndromes of a received codeword.
- Launches each evaluation, holds the evaluation point stable, captures each result into a syndrome register file, and steps the root by alpha with an internal xtime.
- Flags nonzero syndromes and evaluator timeouts.
- Sits between the decoder top-level controller and the polynomial evaluator instance.

Parameters:
- NSYM, 16, number of syndromes (evaluation points), 1..255.
- POLY, 8'h1D, low byte of the GF(2^8) primitive polynomial (0x11D).
- TIMEOUT, 1024, maximum WAIT cycles per evaluation before abort, >=2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a syndrome pass; sampled only in IDLE
- fcr_root  in  8  alpha^FCR, first evaluation point; latched on accepted start
- busy  out  1  high from the cycle after start is accepted until DONE exits
- done  out  1  one-cycle pulse at the end of a pass
- error_detected  out  1  OR of (syndrome != 0) over the pass; valid from done, held until next start
- timeout  out  1  pass aborted by watchdog; valid from done, held until next start
- eval_start  out  1  one-cycle pulse restarting the evaluator
- eval_x  out  8  current evaluation point; stable from eval_start until its result is captured
- eval_done  in  1  evaluator result valid
- eval_result  in  8  evaluator result
- synd_rd_addr  in  clog2(NSYM) (min 1)  syndrome read index
- synd_rd_data  out  8  syndrome[synd_rd_addr], combinational read; out-of-range addresses return 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy, done, eval_start, error_detected and timeout = 0; eval_x=0; all syndromes=0; idx=0; watchdog=0.
  - Reset mid-pass aborts the pass immediately; no done pulse.
- FSM states: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - start=1 → latch root=fcr_root, idx=0, clear error_detected and timeout, go to LAUNCH.
  - Syndrome contents are retained until overwritten.
- LAUNCH (1 cycle):
  - eval_start=1, eval_x=root, watchdog=0 → WAIT.
- WAIT:
  - eval_done is ignored in the first WAIT cycle, because a stale data_ready from the previous evaluation may still be high.
  - From the second WAIT cycle, eval_done=1 →
    - syndrome[idx] <= eval_result
    - error_detected |= (eval_result != 0)
    - root <= xtime(root)
    - if idx==NSYM-1 → DONE; else idx++ → LAUNCH.
  - Watchdog increments every WAIT cycle. If it reaches TIMEOUT-1 with no accepted eval_done → timeout=1, go to DONE; the current and remaining syndromes are not written.
  - If eval_done and watchdog expiry occur in the same cycle, eval_done wins.
- DONE (1 cycle):
  - done=1, busy=0 in the next cycle, go to IDLE.
- xtime(r) = {r[6:0],1'b0} ^ (r[7] ? POLY : 8'h00). Example sequence: 0x80 → 0x1D → 0x3A.
- start while busy is ignored, not queued.
- Timing: E = cycles from the eval_start cycle to the cycle eval_done is accepted (E>=2). Each point takes E+1 cycles. If start is sampled in cycle 0, done is high in cycle NSYM*(E+1)+1.
- eval_x holds its value in IDLE and DONE.

Test Plan:
1. NSYM=4, fcr_root=0x01, bench evaluator echoes eval_x with E=3 → eval_x sequence 01,02,04,08; syndromes 01,02,04,08; error_detected=1, timeout=0; done pulses exactly in cycle 17; exactly 4 eval_start pulses.
2. Same setup, evaluator returns 0x00 → all syndromes 0; error_detected=0; done in cycle 17.
3. NSYM=3, fcr_root=0x80 → eval_x sequence 80,1D,3A.
4. TIMEOUT=16, evaluator never asserts eval_done → timeout=1 and done after 16 WAIT cycles; syndrome[0] unchanged from its prior value; only 1 eval_start.
5. eval_done held high continuously with eval_result=0x55, NSYM=2 → each point is captured on its second WAIT cycle (E=2); syndromes 55,55; done in cycle 7.
6. start pulsed mid-pass → ignored. rst_n pulsed low mid-pass → busy=0, no done, all syndromes 0; a subsequent start runs a full pass normally.

Source files
------------

// File: rtl/syndrome_scheduler.sv
// Reed-Solomon syndrome sequencer: drives one shared Horner evaluator over NSYM
// consecutive roots alpha^(FCR+j) and collects each result in a register file.
module syndrome_scheduler #(
  parameter int         NSYM    = 16,
  parameter logic [7:0] POLY    = 8'h1D,
  parameter int         TIMEOUT = 1024,
  localparam int        AW      = (NSYM > 1) ? $clog2(NSYM) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    fcr_root,
  output logic          busy,
  output logic          done,
  output logic          error_detected,
  output logic          timeout,
  output logic          eval_start,
  output logic [7:0]    eval_x,
  input  logic          eval_done,
  input  logic [7:0]    eval_result,
  input  logic [AW-1:0] synd_rd_addr,
  output logic [7:0]    synd_rd_data
);

  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [7:0]    root;
  logic [AW-1:0] idx;
  logic [WW-1:0] wdog;
  logic [7:0]    syndromes [NSYM];
  logic          accept;
  logic          expire;
  logic          last_point;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? POLY : 8'h00);
  endfunction

  // The first WAIT cycle (watchdog still 0) may see a stale ready from the
  // previous evaluation, so results are only accepted from the second cycle on.
  assign accept     = (state == WAIT) && eval_done && (wdog != '0);
  assign expire     = (state == WAIT) && !accept && (wdog == WW'(TIMEOUT - 1));
  assign last_point = (idx == AW'(NSYM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    eval_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        busy       = 1'b1;
        eval_start = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (accept) begin
          state_next = last_point ? DONE : LAUNCH;
        end else if (expire) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // eval_x is loaded one step ahead of LAUNCH so it is already valid while
  // eval_start is high, and it is frozen after the last point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      root           <= 8'h00;
      idx            <= '0;
      wdog           <= '0;
      eval_x         <= 8'h00;
      error_detected <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            root           <= fcr_root;
            eval_x         <= fcr_root;
            idx            <= '0;
            error_detected <= 1'b0;
            timeout        <= 1'b0;
          end
        end
        LAUNCH: begin
          wdog <= '0;
        end
        WAIT: begin
          wdog <= wdog + WW'(1);
          if (accept) begin
            error_detected <= error_detected | (eval_result != 8'h00);
            root           <= xtime(root);
            if (!last_point) begin
              idx    <= idx + AW'(1);
              eval_x <= xtime(root);
            end
          end else if (expire) begin
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSYM; i++) begin
        syndromes[i] <= 8'h00;
      end
    end else if (accept) begin
      for (int i = 0; i < NSYM; i++) begin
        if (idx == AW'(i)) begin
          syndromes[i] <= eval_result;
        end
      end
    end
  end

  // Addresses at or beyond NSYM match no entry and read back as zero.
  always_comb begin
    synd_rd_data = 8'h00;
    for (int i = 0; i < NSYM; i++) begin
      if (synd_rd_addr == AW'(i)) begin
        synd_rd_data = syndromes[i];
      end
    end
  end

endmodule
